uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the team's fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- Validates the start bit, rejecting glitches; reports parity and framing errors per frame.
- Buffers received frames in a small FIFO with a valid/ready output handshake.
- Sits between the board RxD pin and the image-processing pixel loader.

Parameters:
CLK_FREQ, 6_250_000, system clock frequency in Hz
BAUD_RATE, 230400, line rate in bit/s
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, ≥2)
DIV (derived), CLK_FREQ/BAUD_RATE truncated, clocks per bit (27 at defaults)
HALF (derived), DIV/2 truncated (13 at defaults)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
RxD  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  data field of the FIFO head entry
rx_parity_err  output  1  parity error flag of the head entry (0 when PARITY=0)
rx_frame_err  output  1  framing error flag of the head entry
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts the head entry when rx_valid & rx_ready
overrun  output  1  1-cycle pulse: completed frame dropped because the FIFO was full
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: one clock with reset=1 sets FSM=IDLE, all counters 0, FIFO empty, both synchronizer flops 1, outputs 0 (rx_data, errors, rx_valid, overrun, busy).
- RxD passes through a 2-flop synchronizer (rxs). All timing below is relative to rxs (2-cycle pin delay).
- Start detection requires rxs=0 while the previous rxs sample was 1.
- Line held low across reset does not start a frame; reception waits for a high then a falling edge.
- IDLE: on falling edge of rxs, cnt=0 and go to START.
- START: cnt increments each cycle.
  - At cnt==HALF: rxs=1 means false start, return to IDLE with no push and no flag.
  - rxs=0 means cnt=0, bit_idx=0, go to DATA.
- DATA: when cnt reaches DIV-1, sample rxs into shift[bit_idx] and clear cnt, so the sample falls at bit centre. After bit DATA_BITS-1: go to PARITY if PARITY≠0, else STOP.
- PARITY: sample at cnt==DIV-1.
  - Odd mode: error if XOR(data, parity bit) ≠ 1.
  - Even mode: error if XOR(data, parity bit) ≠ 0.
- STOP: sample each of STOP_BITS stop bits at cnt==DIV-1. Any stop sample =0 sets frame_err.
- Push: on the clock edge taking the final stop sample, write {frame_err, parity_err, data} to the FIFO.
  - rx_valid is high in the following cycle.
  - Then go to IDLE if rxs=1, else BREAK.
- BREAK: wait until rxs=1, then go to IDLE. This prevents a held-low break from being re-read as frames.
- FIFO: circular buffer with read/write pointers plus a count of width log2(FIFO_DEPTH)+1. Head outputs are combinational from the read pointer.
- Pop: when rx_valid & rx_ready at the edge, the read pointer advances. rx_ready while empty has no effect.
- Push when full with no pop in the same cycle: frame discarded, FIFO unchanged, overrun=1 for exactly one cycle.
- Simultaneous push and pop when full: the pop frees a slot, so the push succeeds, count is unchanged and overrun=0.
- Simultaneous push and pop when empty is impossible: the push becomes visible the next cycle.
- Reset mid-frame or with a non-empty FIFO: state, partial data and all stored entries are discarded immediately.
- busy=1 in every state except IDLE.

Test Plan:
1. Defaults 8N1, send 0xA5 at DIV=27, rx_ready=1 → one rx_valid cycle, rx_data=0xA5, both errors 0; rx_valid rises 2+13+27·9+1 cycles after the RxD falling edge (±1).
2. PARITY=2, DATA_BITS=7: send 0x3C with correct parity, then 0x3C with parity bit flipped → entries 0x3C/err 0, then 0x3C/rx_parity_err=1.
3. Stop bit driven 0 and RxD held low 100 cycles → single entry with rx_frame_err=1, FSM in BREAK until RxD=1; no second frame pushed.
4. 5-cycle low glitch on idle RxD → no push, busy returns to 0 within HALF+3 cycles, no flags.
5. rx_ready=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 → overrun pulses once at frame 5; draining yields 0x01..0x04 in order, then rx_valid=0.
6. Assert reset mid-data-bit with 2 entries queued and RxD low → rx_valid=0, busy=0 after reset; no frame starts until RxD goes high then low; next frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: validated start bit, optional parity, 1 or 2 stop bits,
// per-frame error flags and a small receive FIFO with a valid/ready output handshake.
module uart_rx_param #(
   parameter int CLK_FREQ   = 6_250_000,
   parameter int BAUD_RATE  = 230400,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun,
   output logic                 busy
);
   localparam int DIV  = CLK_FREQ / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam int IW   = $clog2(DATA_BITS);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int EW   = DATA_BITS + 2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [IW-1:0]        bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 par_err, par_err_n;
   logic                 frm_err, frm_err_n;
   logic                 stop_idx, stop_idx_n;
   logic                 push;
   logic [EW-1:0]        entry;

   logic                 rx_meta, rxs, rxs_prev;
   logic [1:0]           settle;
   logic                 armed;

   // rxs only reflects the pin two cycles after reset; a line that is low then must
   // be seen high before any falling edge is trusted.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
         settle   <= '0;
         armed    <= 1'b0;
      end else begin
         rx_meta  <= RxD;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
         settle   <= {settle[0], 1'b1};
         armed    <= armed | (settle[1] & rxs);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
         stop_idx <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
         par_err  <= par_err_n;
         frm_err  <= frm_err_n;
         stop_idx <= stop_idx_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      par_err_n  = par_err;
      frm_err_n  = frm_err;
      stop_idx_n = stop_idx;
      push       = 1'b0;
      case (state)
         S_IDLE: begin
            if (armed && rxs_prev && !rxs) begin
               cnt_n   = '0;
               state_n = S_START;
            end
         end
         S_START: begin
            if (cnt == CW'(HALF)) begin
               if (rxs) begin
                  state_n = S_IDLE;
               end else begin
                  cnt_n     = '0;
                  bit_idx_n = '0;
                  par_err_n = 1'b0;
                  state_n   = S_DATA;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt == CW'(DIV - 1)) begin
               cnt_n            = '0;
               shift_n[bit_idx] = rxs;
               if (bit_idx == IW'(DATA_BITS - 1)) begin
                  frm_err_n  = 1'b0;
                  stop_idx_n = 1'b0;
                  state_n    = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_PARITY: begin
            if (cnt == CW'(DIV - 1)) begin
               cnt_n = '0;
               // odd mode expects XOR(data, parity) = 1, even mode expects 0
               par_err_n = (^shift) ^ rxs ^ (PARITY == 1);
               state_n   = S_STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt == CW'(DIV - 1)) begin
               cnt_n = '0;
               if (!rxs) frm_err_n = 1'b1;
               if (stop_idx == 1'(STOP_BITS - 1)) begin
                  push    = 1'b1;
                  state_n = rxs ? S_IDLE : S_BREAK;
               end else begin
                  stop_idx_n = stop_idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_BREAK: begin
            if (rxs) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign entry = {frm_err_n, par_err, shift};
   assign busy  = (state != S_IDLE);

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          pop, full, wr_en;
   logic [EW-1:0] head;

   assign pop   = rx_valid & rx_ready;
   assign full  = (count == (AW + 1)'(FIFO_DEPTH));
   assign wr_en = push & (~full | pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         count   <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
         overrun <= push & full & ~pop;
      end
   end

   assign rx_valid      = (count != '0);
   assign head          = mem[rd_ptr];
   assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign rx_parity_err = rx_valid & head[DATA_BITS];
   assign rx_frame_err  = rx_valid & head[DATA_BITS+1];

endmodule
